// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce the word, invert for odd parity.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity makes the total count of ones even; odd flips that.
  always_comb begin
    par_bit = (^data) ^ (par_typ == PAR_ODD);
  end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity,
// one or two stop bits, each bit registered onto TX_OUT on a BAUD_TICK edge.
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BAUD_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  BUSY,
  output logic                  TX_OUT
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit;

  // Parity is derived from the latched word so late input changes cannot leak in.
  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  // State, output and latch registers; reset forces the line idle-high at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_q       <= STOP_BIT;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
    end
  end

  // Next-state and next-output logic; acceptance ignores BAUD_TICK, all
  // bit transitions wait for it.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;

    unique case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (DATA_VALID) begin
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          stop2_d    = STOP2;
          busy_d     = 1'b1;
          cnt_d      = '0;
          stop_cnt_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (BAUD_TICK) begin
          tx_d    = START_BIT;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (BAUD_TICK) begin
          tx_d = data_q[cnt_q];
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (BAUD_TICK) begin
          tx_d    = par_bit;
          state_d = STOP;
        end
      end
      STOP: begin
        if (BAUD_TICK) begin
          tx_d = STOP_BIT;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign BUSY   = busy_q;
  assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for the UART TX serializer: 8-bit and 5-bit instances,
// expected frames written out by hand as bit strings in transmit order.
module tb_uart_tx_frame_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BAUD_TICK = 1'b0;
  logic [7:0] P_DATA8 = '0;
  logic [4:0] P_DATA5 = '0;
  logic       DV8 = 1'b0;
  logic       DV5 = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic       BUSY8, TX8, BUSY5, TX5;

  int n_chk = 0;
  int n_bad = 0;
  int period = 1;
  int phase = 0;
  int since_tick = 0;
  int last_gap = 0;

  uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .BAUD_TICK(BAUD_TICK), .P_DATA(P_DATA8),
    .DATA_VALID(DV8), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .BUSY(BUSY8), .TX_OUT(TX8)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .BAUD_TICK(BAUD_TICK), .P_DATA(P_DATA5),
    .DATA_VALID(DV5), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .BUSY(BUSY5), .TX_OUT(TX5)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // One clock; reports whether that edge carried a baud tick.
  task automatic step(output bit t);
    t = BAUD_TICK;
    @(posedge CLK);
    #1;
    since_tick++;
    if (t) begin
      last_gap   = since_tick;
      since_tick = 0;
    end
    phase     = (phase + 1) % period;
    BAUD_TICK = (phase == period - 1);
  endtask

  task automatic set_period(input int p);
    period     = p;
    phase      = 0;
    since_tick = 0;
    BAUD_TICK  = (p == 1);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(t);
  endtask

  task automatic send_frame(input string tag, input bit sel5, input logic [8:0] data,
                            input logic pe, input logic pt, input logic s2,
                            input string exp, input int exp_busy, input bit b2b,
                            input int repulse_at);
    bit   t;
    int   busy_cnt;
    int   waitc;
    logic prev, held, cur;
    P_DATA8 = data[7:0];
    P_DATA5 = data[4:0];
    PAR_EN  = pe;
    PAR_TYP = pt;
    STOP2   = s2;
    if (sel5) DV5 = 1'b1;
    else      DV8 = 1'b1;
    step(t);
    DV8 = 1'b0;
    DV5 = 1'b0;
    P_DATA8 = ~data[7:0];
    P_DATA5 = ~data[4:0];
    PAR_EN  = ~pe;
    PAR_TYP = ~pt;
    STOP2   = ~s2;
    chk($sformatf("%s busy_on", tag), sel5 ? BUSY5 : BUSY8, 1);
    busy_cnt = int'(sel5 ? BUSY5 : BUSY8);
    prev = 1'b1;
    cur  = 1'b1;
    for (int i = 0; i < exp.len(); i++) begin
      held  = 1'b1;
      waitc = 0;
      t     = 1'b0;
      if (i == repulse_at) begin
        P_DATA8 = 8'hFF;
        DV8     = 1'b1;
      end
      while (!t && waitc < 64) begin
        step(t);
        waitc++;
        DV8 = 1'b0;
        cur = sel5 ? TX5 : TX8;
        busy_cnt += int'(sel5 ? BUSY5 : BUSY8);
        if (!t && cur !== prev) held = 1'b0;
      end
      chk($sformatf("%s tick%0d", tag, i), t, 1);
      chk($sformatf("%s hold%0d", tag, i), held, 1);
      chk($sformatf("%s bit%0d", tag, i), cur, (exp[i] == 8'h31));
      if (i > 0 || b2b) chk($sformatf("%s gap%0d", tag, i), last_gap, period);
      prev = cur;
    end
    chk($sformatf("%s busy_off", tag), sel5 ? BUSY5 : BUSY8, 0);
    if (exp_busy > 0) chk($sformatf("%s busy_len", tag), busy_cnt, exp_busy);
  endtask

  initial begin
    bit t;

    // Reset held with random inputs: line idle, not busy.
    set_period(1);
    for (int i = 0; i < 6; i++) begin
      P_DATA8   = 8'($urandom);
      P_DATA5   = 5'($urandom);
      DV8       = 1'($urandom);
      DV5       = 1'($urandom);
      PAR_EN    = 1'($urandom);
      BAUD_TICK = 1'($urandom);
      step(t);
      chk("rst tx8", TX8, 1);
      chk("rst busy8", BUSY8, 0);
      chk("rst tx5", TX5, 1);
      chk("rst busy5", BUSY5, 0);
    end
    DV8 = 1'b0;
    DV5 = 1'b0;
    set_period(1);
    RST = 1'b1;
    idle(2);
    chk("post-rst tx8", TX8, 1);

    // Basic frame; accept and tick coincide on every edge at period 1.
    send_frame("a5", 0, 9'h0A5, 0, 0, 0, "0101001011", 10, 0, -1);
    idle(3);
    send_frame("07even2", 0, 9'h007, 1, 0, 1, "011100000111", 12, 0, -1);
    idle(3);
    send_frame("07odd", 0, 9'h007, 1, 1, 0, "01110000001", 11, 0, -1);
    idle(3);

    // Asynchronous reset in the middle of the data bits.
    P_DATA8 = 8'hA5;
    DV8 = 1'b1;
    step(t);
    DV8 = 1'b0;
    idle(3);
    chk("pre-abort tx", TX8, 0);
    #2 RST = 1'b0;
    #1;
    chk("abort tx", TX8, 1);
    chk("abort busy", BUSY8, 0);
    #2 RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(t);
      chk("after-abort tx", TX8, 1);
      chk("after-abort busy", BUSY8, 0);
    end

    // Slow baud with a request pulsed mid-frame that must be ignored.
    set_period(16);
    idle(5);
    send_frame("3c", 0, 9'h03C, 0, 0, 0, "0001111001", 0, 0, 3);
    idle(20);

    // Back-to-back: second request on the cycle after BUSY falls.
    set_period(4);
    idle(2);
    send_frame("b2b00", 0, 9'h000, 0, 0, 0, "0000000001", 0, 0, -1);
    send_frame("b2bff", 0, 9'h0FF, 0, 0, 0, "0111111111", 0, 1, -1);
    idle(6);

    // Narrow instance with odd parity.
    set_period(1);
    idle(2);
    send_frame("w5", 1, 9'h013, 1, 1, 0, "01100101", 8, 0, -1);
    chk("w5 tx8 idle", TX8, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
